// File: rtl/mul_x_pkg.sv
// Shared definitions for the registered signed 32x32 multiplier.
//   OP_W    : operand width (32)
//   PROD_W  : full-precision product width (64)
//   NUM_PP  : number of radix-4 Booth partial products (16)
//   booth_digit_t : recoded multiplier digit in {0, +1, +2, -1, -2}
//   booth_encode  : maps an overlapping multiplier bit triplet to its digit
package mul_x_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;
  localparam int NUM_PP = OP_W / 2;

  typedef enum logic [2:0] {
    BD_ZERO = 3'd0,
    BD_POS1 = 3'd1,
    BD_POS2 = 3'd2,
    BD_NEG1 = 3'd3,
    BD_NEG2 = 3'd4
  } booth_digit_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}; value = -2*t[2] + t[1] + t[0].
  function automatic booth_digit_t booth_encode(input logic [2:0] trip);
    booth_digit_t d;
    case (trip)
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_mul32_core.sv
// Purely combinational signed 32x32 -> 64 multiplier.
// Radix-4 modified Booth recoding of b gives 16 partial products of a, each
// sign-extended to 64 bits. They are reduced by a linear chain of 3:2
// carry-save adders and a single carry-propagate add yields the product.
//   a : signed multiplicand (32)
//   b : signed multiplier   (32)
//   p : signed product      (64)
module booth_mul32_core
  import mul_x_pkg::*;
(
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic signed [PROD_W-1:0] p
);

  logic [PROD_W-1:0] a_ext;
  logic [OP_W:0]     b_pad;
  logic [PROD_W-1:0] pp_cur;
  logic [PROD_W-1:0] s_acc;
  logic [PROD_W-1:0] c_acc;
  logic [PROD_W-1:0] s_nxt;

  // Scales the sign-extended multiplicand by one Booth digit. Everything is
  // modulo 2^64, so negation by two's complement is exact at this width.
  function automatic logic [PROD_W-1:0] booth_pp(input booth_digit_t d,
                                                 input logic [PROD_W-1:0] m);
    logic [PROD_W-1:0] r;
    case (d)
      BD_POS1: r = m;
      BD_POS2: r = m << 1;
      BD_NEG1: r = -m;
      BD_NEG2: r = -(m << 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign a_ext = {{(PROD_W-OP_W){a[OP_W-1]}}, a};
  // Implicit b[-1] = 0 appended below the LSB for the first triplet.
  assign b_pad = {b, 1'b0};

  // Carry-save reduction: the running (sum, carry) pair absorbs one partial
  // product per step; carries shift left by one, overflow beyond bit 63
  // is discarded which is correct for modulo-2^64 arithmetic.
  always_comb begin
    s_acc  = '0;
    c_acc  = '0;
    s_nxt  = '0;
    pp_cur = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      pp_cur = booth_pp(booth_encode(b_pad[2*i +: 3]), a_ext) << (2*i);
      s_nxt  = s_acc ^ c_acc ^ pp_cur;
      c_acc  = ((s_acc & c_acc) | (s_acc & pp_cur) | (c_acc & pp_cur)) << 1;
      s_acc  = s_nxt;
    end
  end

  assign p = signed'(s_acc + c_acc);

endmodule

// File: rtl/mul_x_with_regs.sv
// Registered signed 32x32 multiplier, fixed two-cycle pipeline.
// Operands are captured, multiplied combinationally by booth_mul32_core, and
// the 64-bit product is captured in the output register.
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset, clears every register
//   en         : single enable for the whole pipe (low = all stages hold)
//   a, b       : signed 32-bit operands
//   MulXResult : signed 64-bit product, straight from the output register
module mul_x_with_regs
  import mul_x_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic signed [PROD_W-1:0] MulXResult
);

  logic signed [OP_W-1:0]   a_p1;
  logic signed [OP_W-1:0]   b_p1;
  logic signed [PROD_W-1:0] prod_p1;

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_p1 <= '0;
      b_p1 <= '0;
    end else if (en) begin
      a_p1 <= a;
      b_p1 <= b;
    end
  end

  // Combinational multiply between the two register stages
  booth_mul32_core u_core (
    .a (a_p1),
    .b (b_p1),
    .p (prod_p1)
  );

  // Stage 2: product capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MulXResult <= '0;
    end else if (en) begin
      MulXResult <= prod_p1;
    end
  end

endmodule

// File: tb/tb_mul_x_with_regs.sv
// Scoreboard bench for mul_x_with_regs. Stimulus pushes the mathematically
// expected product of each enabled operand pair; the monitor pops one entry
// at every enabled edge. The model tracks the pipe as a queue whose head is
// what the output register loads next (0 right after reset: cleared operands).
module tb_mul_x_with_regs;

  logic               clk;
  logic               reset;
  logic               en;
  logic signed [31:0] a;
  logic signed [31:0] b;
  logic signed [63:0] MulXResult;

  mul_x_with_regs dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .a          (a),
    .b          (b),
    .MulXResult (MulXResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint exp_q[$];
  longint prev_exp;
  int     n_checks;
  int     n_fail;

  function automatic longint prod(input int x, input int y);
    return longint'(x) * longint'(y);
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input longint expv);
    n_checks++;
    if (act !== 64'(expv)) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(0);
    prev_exp = 0;
  endtask

  // One clock of stimulus, applied on the falling edge.
  task automatic cycle(input int x, input int y, input bit e, input bit r);
    @(negedge clk);
    a = x;
    b = y;
    en = e;
    reset = r;
    if (!r) model_reset();
    else if (e) exp_q.push_back(prod(x, y));
  endtask

  // Monitor
  bit     en_s;
  bit     rst_s;
  longint mon_e;
  always @(posedge clk) begin
    en_s  = en;
    rst_s = reset;
    #1;
    if (!rst_s) begin
      chk("reset_hold", MulXResult, 0);
    end else if (en_s) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got output %0d expected no pending product", MulXResult);
      end else begin
        mon_e = exp_q.pop_front();
        prev_exp = mon_e;
        chk("product", MulXResult, mon_e);
      end
    end else begin
      chk("stall_hold", MulXResult, prev_exp);
    end
  end

  int seq_a[7] = '{2, -12, -9, 11, 10, 4, -1};
  int seq_b[7] = '{3, -4, 5, 0, 1, 6, -7};
  int corner[6] = '{32'h8000_0000, 32'h7fff_ffff, 1, -1, 0, 2};

  function automatic int rnd_op();
    if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 5)];
    return int'($urandom);
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    model_reset();
    #1;
    chk("reset_initial", MulXResult, 0);

    // Reset held with live operands and enable
    repeat (3) cycle(5, -7, 1'b1, 1'b0);
    repeat (2) cycle(5, -7, 1'b1, 1'b1);

    // Directed sequence, each pair held for two cycles
    for (int i = 0; i < 7; i++) begin
      cycle(seq_a[i], seq_b[i], 1'b1, 1'b1);
      cycle(seq_a[i], seq_b[i], 1'b1, 1'b1);
    end

    // Corner operands
    cycle(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    cycle(32'h8000_0000, 1, 1'b1, 1'b1);
    cycle(32'h7fff_ffff, 32'h7fff_ffff, 1'b1, 1'b1);
    cycle(32'h8000_0000, 32'h7fff_ffff, 1'b1, 1'b1);

    // Back-to-back streaming
    cycle(3, 4, 1'b1, 1'b1);
    cycle(-5, 6, 1'b1, 1'b1);
    cycle(7, -8, 1'b1, 1'b1);

    // Enable stall with operands wiggling while frozen
    cycle(9, 9, 1'b1, 1'b1);
    repeat (3) cycle(rnd_op(), rnd_op(), 1'b0, 1'b1);
    cycle(1, 1, 1'b1, 1'b1);
    cycle(1, 1, 1'b1, 1'b1);

    // Asynchronous reset between edges with products in flight
    cycle(123, 456, 1'b1, 1'b1);
    cycle(-77, 88, 1'b1, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_immediate", MulXResult, 0);
    model_reset();
    repeat (2) cycle(-77, 88, 1'b1, 1'b0);
    cycle(13, -3, 1'b1, 1'b1);
    cycle(13, -3, 1'b1, 1'b1);
    cycle(13, -3, 1'b1, 1'b1);

    // Randomized traffic with random stalls and occasional resets
    for (int i = 0; i < 400; i++) begin
      cycle(rnd_op(), rnd_op(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 59) != 0));
    end

    repeat (3) cycle(0, 0, 1'b1, 1'b1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
